potential_decay_store: RTL and testbench
========================================

Name: potential_decay_store

Overview:
- Per-neuron membrane-potential register and decay stage; sits on the opposite side of the potential adder interface.
- Each timestep it decays the stored FP32 potential and drives the result into the adder's decayed-potential input.
- It sequences the adder's set/clear controls, waits for the combinational adder to settle, then captures the adder's final potential and spike.
- The captured value is the stored state for the next timestep.

Parameters:
- DECAY_SHIFT, 1: decay factor 2^-DECAY_SHIFT, applied as an FP32 exponent decrement; legal range 1..7.
- V_REST, 32'h00000000: FP32 potential loaded at reset and on init.
- SETTLE_CYCLES, 2: cycles the adder outputs are allowed to settle before capture; legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- init  in  1  one-cycle pulse: reload V_REST and pulse adder set.
- timestep_start  in  1  one-cycle pulse: run one decay/accumulate/capture cycle.
- final_potential_in  in  32  FP32 final potential from the adder.
- spike_in  in  1  spike from the adder.
- decayed_potential  out  32  FP32 decayed potential, to the adder.
- adder_set  out  1  drives the adder's set input.
- adder_clear  out  1  drives the adder's clear input.
- potential  out  32  stored FP32 membrane potential.
- spike_out  out  1  registered spike for the current timestep.
- spike_count  out  16  saturating spike total.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse on capture.
- overrun  out  1  sticky: timestep_start received while busy.

Behaviour:
- Reset values:
  - potential = V_REST; decayed_potential = 0.
  - adder_clear = 1; adder_set = 0.
  - spike_out = 0; spike_count = 0.
  - busy = 0; done = 0; overrun = 0; state = IDLE.
- All outputs are registered.
- States:
  - IDLE: adder_clear = 1. On init, go to INIT. Otherwise, on timestep_start, go to DECAY.
  - INIT (1 cycle): potential <= V_REST; adder_set = 1; adder_clear = 0; spike_out <= 0. Next state IDLE.
  - DECAY (1 cycle): decayed_potential <= decay(potential); adder_clear <= 0. Next state SETTLE, with the settle counter loaded to SETTLE_CYCLES-1.
  - SETTLE: decayed_potential is held stable. Decrement the counter; at 0, go to CAPTURE.
  - CAPTURE (1 cycle):
    - potential <= final_potential_in; spike_out <= spike_in.
    - If spike_in = 1 and spike_count is below 16'hFFFF, increment spike_count.
    - done = 1; adder_clear <= 1. Next state IDLE.
- decay(x), with sign s, exponent e, mantissa m:
  - e == 8'hFF (Inf/NaN): pass through unchanged.
  - e <= DECAY_SHIFT, which includes zero and denormals: result is +0 (32'h00000000).
  - Otherwise: {s, e-DECAY_SHIFT, m}.
- Latency: timestep_start to done = 2 + SETTLE_CYCLES + 1 cycles; 5 with defaults (DECAY, SETTLE ×2, CAPTURE, plus the IDLE decision cycle).
- Simultaneous events:
  - init and timestep_start together in IDLE: init wins; timestep_start is dropped and overrun is not set.
  - timestep_start while busy: ignored; overrun <= 1 (sticky, cleared only by RST).
  - init while busy: ignored.
- Reset mid-operation: immediate return to reset values. The in-flight capture is lost, and the adder sees clear = 1 asynchronously.
- The adder's spike is sampled only in CAPTURE; spike_in in any other state is ignored.

Test Plan:
- Reset then timestep_start with potential = V_REST = 0: decayed_potential = 0 within 1 cycle of DECAY; bench adder returns 0x41F00000 (30.0, no spike); done on the 5th cycle; potential = 0x41F00000; spike_out = 0.
- Stored 0x42400000 (48.0), DECAY_SHIFT = 1: decayed_potential = 0x41C00000 (24.0). Bench returns 0x41000000 with spike_in = 1. After capture: potential = 0x41000000, spike_out = 1, spike_count = 1.
- Stored 0x00800000 (e = 1) → decayed_potential = 0. Stored 0xC2200000 → 0xC1A00000. Stored 0x7F800000 → 0x7F800000.
- timestep_start asserted at cycle 2 of a run: ignored, overrun = 1, done still after 5 cycles. Then init with timestep_start in IDLE: adder_set pulses 1 cycle, potential = V_REST, no run starts.
- Preload spike_count = 16'hFFFE via 2 forced captures in a reduced-width build, or run 65535 spiking timesteps: count stays at 16'hFFFF on further spikes.
- RST asserted during SETTLE: all outputs return to reset values the same cycle (asynchronous); potential is not updated from final_potential_in.

Source files
------------

// File: rtl/potential_decay_store.sv
// Membrane-potential store for one neuron: decays the stored FP32 potential, sequences the
// external combinational adder through set/clear, then captures its result and spike.
module potential_decay_store #(
    parameter int unsigned DECAY_SHIFT   = 1,
    parameter logic [31:0] V_REST        = 32'h0000_0000,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        init,
    input  logic        timestep_start,
    input  logic [31:0] final_potential_in,
    input  logic        spike_in,
    output logic [31:0] decayed_potential,
    output logic        adder_set,
    output logic        adder_clear,
    output logic [31:0] potential,
    output logic        spike_out,
    output logic [15:0] spike_count,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        DECAY   = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       settle_cnt;
    logic [CNT_W-1:0] spike_cnt;
    logic             adder_set_d;
    logic             adder_clear_d;
    logic             busy_d;
    logic             done_d;

    // Multiply by 2^-DECAY_SHIFT via the exponent; anything that would go subnormal flushes to +0.
    function automatic logic [31:0] decay(input logic [31:0] x);
        logic [7:0] e;
        e = x[30:23];
        if (e == 8'hFF)
            return x;
        else if (e <= 8'(DECAY_SHIFT))
            return 32'h0000_0000;
        else
            return {x[31], e - 8'(DECAY_SHIFT), x[22:0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (init)
                    next_state = INIT;
                else if (timestep_start)
                    next_state = DECAY;
            end
            INIT:    next_state = IDLE;
            DECAY:   next_state = SETTLE;
            SETTLE:  if (settle_cnt == 4'd0) next_state = CAPTURE;
            CAPTURE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Values the registered control outputs take at the end of the current state.
    always_comb begin
        adder_set_d   = (state == INIT);
        adder_clear_d = !((state == INIT) || (state == DECAY) || (state == SETTLE));
        busy_d        = (next_state != IDLE);
        done_d        = (state == CAPTURE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            potential         <= V_REST;
            decayed_potential <= 32'h0000_0000;
            adder_set         <= 1'b0;
            adder_clear       <= 1'b1;
            spike_out         <= 1'b0;
            spike_cnt         <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            overrun           <= 1'b0;
            settle_cnt        <= 4'd0;
        end else begin
            adder_set   <= adder_set_d;
            adder_clear <= adder_clear_d;
            busy        <= busy_d;
            done        <= done_d;
            if ((state != IDLE) && timestep_start)
                overrun <= 1'b1;
            case (state)
                INIT: begin
                    potential <= V_REST;
                    spike_out <= 1'b0;
                end
                DECAY: begin
                    decayed_potential <= decay(potential);
                    settle_cnt        <= 4'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (settle_cnt != 4'd0)
                        settle_cnt <= settle_cnt - 4'd1;
                end
                CAPTURE: begin
                    potential <= final_potential_in;
                    spike_out <= spike_in;
                    if (spike_in)
                        spike_cnt <= sat_inc(spike_cnt);
                end
                default: ;
            endcase
        end
    end

    assign spike_count = 16'(spike_cnt);

endmodule

// File: tb/tb_potential_decay_store.sv
// Directed bench for potential_decay_store: decay arithmetic, run timing, init, overrun,
// spike-count saturation (narrow-counter twin instance) and asynchronous reset.
module tb_potential_decay_store;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        init = 1'b0;
    logic        timestep_start = 1'b0;
    logic [31:0] final_potential_in = 32'hDEAD_BEEF;
    logic        spike_in = 1'b1;

    logic [31:0] decayed_potential, potential;
    logic        adder_set, adder_clear, spike_out, busy, done, overrun;
    logic [15:0] spike_count;

    logic [31:0] sat_decayed_potential, sat_potential;
    logic        sat_adder_set, sat_adder_clear, sat_spike_out, sat_busy, sat_done, sat_overrun;
    logic [15:0] sat_spike_count;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] model_cnt = 16'd0;
    logic [15:0] model_sat = 16'd0;
    logic        model_ovr = 1'b0;

    always #5 CLK = ~CLK;

    potential_decay_store dut (
        .CLK(CLK), .RST(RST), .init(init), .timestep_start(timestep_start),
        .final_potential_in(final_potential_in), .spike_in(spike_in),
        .decayed_potential(decayed_potential), .adder_set(adder_set), .adder_clear(adder_clear),
        .potential(potential), .spike_out(spike_out), .spike_count(spike_count),
        .busy(busy), .done(done), .overrun(overrun)
    );

    // Same stimulus, 2-bit spike counter so saturation is reachable in a few timesteps.
    potential_decay_store #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .RST(RST), .init(init), .timestep_start(timestep_start),
        .final_potential_in(final_potential_in), .spike_in(spike_in),
        .decayed_potential(sat_decayed_potential), .adder_set(sat_adder_set),
        .adder_clear(sat_adder_clear), .potential(sat_potential), .spike_out(sat_spike_out),
        .spike_count(sat_spike_count), .busy(sat_busy), .done(sat_done), .overrun(sat_overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_potential"}, potential, 32'h0);
        check({tag, "_decayed"}, decayed_potential, 32'h0);
        check({tag, "_clear"}, 32'(adder_clear), 32'd1);
        check({tag, "_set"}, 32'(adder_set), 32'd0);
        check({tag, "_spike_out"}, 32'(spike_out), 32'd0);
        check({tag, "_spike_count"}, 32'(spike_count), 32'd0);
        check({tag, "_sat_count"}, 32'(sat_spike_count), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    // One timestep; adder inputs carry junk (with spike high) except around CAPTURE.
    task automatic run_ts(input logic [31:0] exp_dec, input logic [31:0] ret,
                          input logic spk, input logic poke);
        @(negedge CLK);
        timestep_start = 1'b1;
        @(posedge CLK); #1;
        timestep_start = poke;
        check("busy_start", 32'(busy), 32'd1);
        check("done_early", 32'(done), 32'd0);
        @(posedge CLK); #1;
        timestep_start = 1'b0;
        if (poke) model_ovr = 1'b1;
        check("decayed", decayed_potential, exp_dec);
        check("clear_low", 32'(adder_clear), 32'd0);
        check("overrun", 32'(overrun), 32'(model_ovr));
        @(posedge CLK); #1;
        final_potential_in = ret;
        spike_in = spk;
        check("decayed_hold", decayed_potential, exp_dec);
        @(posedge CLK); #1;
        check("done_pre", 32'(done), 32'd0);
        @(posedge CLK); #1;
        if (spk) begin
            model_cnt = (model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'd1;
            model_sat = (model_sat == 16'd3) ? model_sat : model_sat + 16'd1;
        end
        check("done", 32'(done), 32'd1);
        check("potential", potential, ret);
        check("spike_out", 32'(spike_out), 32'(spk));
        check("spike_count", 32'(spike_count), 32'(model_cnt));
        check("sat_count", 32'(sat_spike_count), 32'(model_sat));
        check("busy_end", 32'(busy), 32'd0);
        check("clear_high", 32'(adder_clear), 32'd1);
        final_potential_in = 32'hDEAD_BEEF;
        spike_in = 1'b1;
        @(posedge CLK); #1;
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check_reset_values("reset");

        run_ts(32'h0000_0000, 32'h41F0_0000, 1'b0, 1'b0);
        run_ts(32'h4170_0000, 32'h4240_0000, 1'b0, 1'b0);
        run_ts(32'h41C0_0000, 32'h4100_0000, 1'b1, 1'b0);
        run_ts(32'h4080_0000, 32'h0080_0000, 1'b0, 1'b0);
        run_ts(32'h0000_0000, 32'hC220_0000, 1'b0, 1'b0);
        run_ts(32'hC1A0_0000, 32'h7F80_0000, 1'b0, 1'b0);
        run_ts(32'h7F80_0000, 32'h3F80_0000, 1'b1, 1'b0);

        // init together with timestep_start: init wins, no run, no overrun
        @(negedge CLK);
        init = 1'b1;
        timestep_start = 1'b1;
        @(posedge CLK); #1;
        init = 1'b0;
        timestep_start = 1'b0;
        check("init_busy", 32'(busy), 32'd1);
        check("init_set_early", 32'(adder_set), 32'd0);
        @(posedge CLK); #1;
        check("init_set", 32'(adder_set), 32'd1);
        check("init_clear", 32'(adder_clear), 32'd0);
        check("init_potential", potential, 32'h0);
        check("init_spike_out", 32'(spike_out), 32'd0);
        check("init_idle", 32'(busy), 32'd0);
        @(posedge CLK); #1;
        check("init_set_end", 32'(adder_set), 32'd0);
        check("init_clear_end", 32'(adder_clear), 32'd1);
        check("init_no_run", 32'(busy), 32'd0);
        check("init_overrun", 32'(overrun), 32'd0);
        check("init_done", 32'(done), 32'd0);

        run_ts(32'h0000_0000, 32'h4000_0000, 1'b1, 1'b0);
        run_ts(32'h3F80_0000, 32'h4040_0000, 1'b1, 1'b1);

        // asynchronous reset while in SETTLE
        @(negedge CLK);
        timestep_start = 1'b1;
        @(posedge CLK); #1;
        timestep_start = 1'b0;
        @(posedge CLK); #1;
        check("pre_reset_decayed", decayed_potential, 32'h3FC0_0000);
        final_potential_in = 32'h1234_5678;
        spike_in = 1'b1;
        @(posedge CLK); #3;
        RST = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("post_reset_potential", potential, 32'h0);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_done", 32'(done), 32'd0);
        check("post_reset_count", 32'(spike_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
